// File: rtl/mul_array_arbiter.sv
// Round-robin arbiter that lends the shared lane-wise GF multiplier array to
// NREQ requesters, one whole operation at a time, with an optional burst lock.
module mul_array_arbiter #(
    parameter int M     = 144,
    parameter int W     = 16,
    parameter int LANES = 9,
    parameter int LAT   = 3,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*M-1:0] o_in,
    input  logic [NREQ*W-1:0] t_in,
    output logic [NREQ-1:0]   ack,
    output logic [M-1:0]      res_dat,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [M-1:0]      arr_o_out,
    output logic [W-1:0]      arr_t_out,
    input  logic [M-1:0]      arr_r_dat
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                    state_q;
    logic [PW-1:0]             rr_ptr_q;
    logic [PW-1:0]             owner_q;
    logic                      lock_valid_q;
    logic [CW-1:0]             cnt_q;
    logic [NREQ-1:0]           ack_q;
    logic [NREQ-1:0]           grant_q;
    logic [LANES-1:0][W-1:0]   res_q;
    logic [LANES-1:0][W-1:0]   arr_o_q;
    logic [W-1:0]              arr_t_q;

    logic [M-1:0]              o_arr [NREQ];
    logic [W-1:0]              t_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_split
            assign o_arr[gi] = o_in[gi*M +: M];
            assign t_arr[gi] = t_in[gi*W +: W];
        end
    endgenerate

    // Rotate requests so bit 0 is the requester at rr_ptr; lowest set bit wins.
    logic [2*NREQ-1:0] req_rot;
    logic              rr_found;
    logic [PW:0]       rr_sum;
    logic [PW-1:0]     rr_win;

    assign req_rot = {req, req} >> rr_ptr_q;

    always_comb begin
        rr_found = 1'b0;
        rr_sum   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr_q} + (PW+1)'(k);
            end
        end
        if (rr_sum >= (PW+1)'(NREQ))
            rr_sum = rr_sum - (PW+1)'(NREQ);
        rr_win = rr_sum[PW-1:0];
    end

    logic          issue_d;
    logic [PW-1:0] win_d;
    logic          lock_drop_d;

    always_comb begin
        issue_d     = 1'b0;
        win_d       = rr_win;
        lock_drop_d = 1'b0;
        if (lock_valid_q && req[owner_q]) begin
            issue_d = 1'b1;
            win_d   = owner_q;
        end else if (lock_valid_q && lock[owner_q]) begin
            issue_d = 1'b0;
        end else begin
            lock_drop_d = lock_valid_q;
            issue_d     = rr_found;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            lock_valid_q <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= '0;
            grant_q      <= '0;
            res_q        <= '0;
            arr_o_q      <= '0;
            arr_t_q      <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (lock_drop_d)
                        lock_valid_q <= 1'b0;
                    if (issue_d) begin
                        owner_q <= win_d;
                        grant_q <= NREQ'(1) << win_d;
                        arr_o_q <= o_arr[win_d];
                        arr_t_q <= t_arr[win_d];
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(LAT - 1)) begin
                        res_q   <= arr_r_dat;
                        ack_q   <= grant_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr_q     <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                    lock_valid_q <= lock[owner_q];
                    grant_q      <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack       = ack_q;
    assign res_dat   = res_q;
    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign arr_o_out = arr_o_q;
    assign arr_t_out = arr_t_q;

endmodule
